// File: rtl/streamer_rx_block_buffer.sv
// Block-granular receive buffer between an rx streamer and a consumer.
// Words are written speculatively and become readable only once their whole block has been committed.
module streamer_rx_block_buffer #(
    parameter int g_data_width      = 64,
    parameter int g_fifo_depth      = 16,
    parameter int g_max_block_words = 8
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_n_i,
    input  logic [g_data_width-1:0] rx_data_i,
    input  logic                    rx_valid_i,
    input  logic                    rx_first_p1_i,
    input  logic                    rx_last_p1_i,
    input  logic                    rx_lost_p1_i,
    output logic                    rx_dreq_o,
    output logic [g_data_width-1:0] blk_data_o,
    output logic                    blk_valid_o,
    output logic                    blk_first_o,
    output logic                    blk_last_o,
    input  logic                    blk_ready_i,
    output logic [15:0]             stat_dropped_o,
    output logic [15:0]             stat_committed_o
);

    localparam int c_aw    = $clog2(g_fifo_depth);
    localparam int c_cw    = $clog2(g_max_block_words + 1);
    localparam int c_lim   = g_fifo_depth - 2;
    localparam int c_one_i = 1;

    localparam logic [c_aw:0]   c_depth     = g_fifo_depth[c_aw:0];
    localparam logic [c_aw:0]   c_dreq_lim  = c_lim[c_aw:0];
    localparam logic [c_aw:0]   c_ptr_one   = c_one_i[c_aw:0];
    localparam logic [c_cw-1:0] c_cnt_one   = c_one_i[c_cw-1:0];
    localparam logic [c_cw-1:0] c_cnt_max   = g_max_block_words[c_cw-1:0];

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_IN_BLOCK = 2'd1;
    localparam logic [1:0] ST_DISCARD  = 2'd2;

    logic [g_data_width-1:0] mem_data_r [g_fifo_depth];
    logic [g_fifo_depth-1:0] mem_first_r;
    logic [g_fifo_depth-1:0] mem_last_r;

    logic [c_aw:0]   wr_ptr_r, commit_ptr_r, rd_ptr_r;
    logic [1:0]      state_r;
    logic [c_cw-1:0] cnt_r;
    logic            dreq_r;
    logic [15:0]     dropped_r, committed_r;

    logic [c_aw:0]   wr_base_s, wr_nxt_s, commit_nxt_s, rd_nxt_s, used_nxt_s;
    logic [1:0]      state_eff_s, state_nxt_s;
    logic [c_cw-1:0] cnt_nxt_s;
    logic            we_s, drop_s, commit_s, full_s, rd_fire_s, blk_valid_s;
    logic [c_aw-1:0] rd_idx_s, wr_idx_s;

    assign rd_idx_s    = rd_ptr_r[c_aw-1:0];
    assign wr_idx_s    = wr_base_s[c_aw-1:0];
    assign blk_valid_s = (rd_ptr_r != commit_ptr_r);
    assign rd_fire_s   = blk_valid_s & blk_ready_i;
    assign rd_nxt_s    = rd_fire_s ? (rd_ptr_r + c_ptr_one) : rd_ptr_r;
    assign used_nxt_s  = wr_nxt_s - rd_nxt_s;

    // Write-side FSM: a truncated or lost block first rewinds, then the word is handled as if idle
    always_comb begin
        wr_base_s    = wr_ptr_r;
        state_eff_s  = state_r;
        drop_s       = 1'b0;
        if ((state_r == ST_IN_BLOCK) && (rx_lost_p1_i || (rx_valid_i && rx_first_p1_i))) begin
            wr_base_s   = commit_ptr_r;
            drop_s      = 1'b1;
            state_eff_s = ST_IDLE;
        end else if ((state_r == ST_DISCARD) && rx_valid_i && rx_first_p1_i) begin
            state_eff_s = ST_IDLE;
        end else begin
            state_eff_s = state_r;
        end

        full_s       = ((wr_base_s - rd_ptr_r) == c_depth);
        state_nxt_s  = state_eff_s;
        wr_nxt_s     = wr_base_s;
        commit_nxt_s = commit_ptr_r;
        cnt_nxt_s    = cnt_r;
        we_s         = 1'b0;
        commit_s     = 1'b0;

        case (state_eff_s)
            ST_IDLE: begin
                if (!rx_valid_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (!rx_first_p1_i) begin
                    // stray word outside a block; a rewind in this cycle already counted the drop
                    drop_s      = 1'b1;
                    state_nxt_s = rx_last_p1_i ? ST_IDLE : ST_DISCARD;
                end else if (full_s) begin
                    wr_nxt_s    = commit_ptr_r;
                    drop_s      = 1'b1;
                    state_nxt_s = ST_DISCARD;
                end else begin
                    we_s      = 1'b1;
                    wr_nxt_s  = wr_base_s + c_ptr_one;
                    cnt_nxt_s = c_cnt_one;
                    if (rx_last_p1_i) begin
                        commit_nxt_s = wr_base_s + c_ptr_one;
                        commit_s     = 1'b1;
                        state_nxt_s  = ST_IDLE;
                    end else begin
                        state_nxt_s  = ST_IN_BLOCK;
                    end
                end
            end
            ST_IN_BLOCK: begin
                if (!rx_valid_i) begin
                    state_nxt_s = ST_IN_BLOCK;
                end else if ((cnt_r == c_cnt_max) || full_s) begin
                    wr_nxt_s    = commit_ptr_r;
                    drop_s      = 1'b1;
                    state_nxt_s = ST_DISCARD;
                end else begin
                    we_s      = 1'b1;
                    wr_nxt_s  = wr_base_s + c_ptr_one;
                    cnt_nxt_s = cnt_r + c_cnt_one;
                    if (rx_last_p1_i) begin
                        commit_nxt_s = wr_base_s + c_ptr_one;
                        commit_s     = 1'b1;
                        state_nxt_s  = ST_IDLE;
                    end else begin
                        state_nxt_s  = ST_IN_BLOCK;
                    end
                end
            end
            ST_DISCARD: begin
                if (rx_valid_i && rx_last_p1_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DISCARD;
                end
            end
            default: begin
                wr_nxt_s    = commit_ptr_r;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Word storage; flags travel with each entry so the reader sees block boundaries
    always_ff @(posedge clk_sys_i) begin
        if (we_s) begin
            mem_data_r[wr_idx_s]  <= rx_data_i;
            mem_first_r[wr_idx_s] <= rx_first_p1_i;
            mem_last_r[wr_idx_s]  <= rx_last_p1_i;
        end
    end

    // Pointer, FSM, request and statistics state
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_r     <= '0;
            commit_ptr_r <= '0;
            rd_ptr_r     <= '0;
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            dreq_r       <= 1'b0;
            dropped_r    <= 16'h0000;
            committed_r  <= 16'h0000;
        end else begin
            wr_ptr_r     <= wr_nxt_s;
            commit_ptr_r <= commit_nxt_s;
            rd_ptr_r     <= rd_nxt_s;
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            // two free entries cover the word that may already be in flight
            dreq_r       <= (used_nxt_s <= c_dreq_lim);
            if (drop_s && (dropped_r != 16'hFFFF)) begin
                dropped_r <= dropped_r + 16'h0001;
            end
            if (commit_s && (committed_r != 16'hFFFF)) begin
                committed_r <= committed_r + 16'h0001;
            end
        end
    end

    assign rx_dreq_o        = dreq_r;
    assign blk_valid_o      = blk_valid_s;
    assign blk_data_o       = mem_data_r[rd_idx_s];
    assign blk_first_o      = blk_valid_s & mem_first_r[rd_idx_s];
    assign blk_last_o       = blk_valid_s & mem_last_r[rd_idx_s];
    assign stat_dropped_o   = dropped_r;
    assign stat_committed_o = committed_r;

endmodule

// File: tb/tb_streamer_rx_block_buffer.sv
// Bench for streamer_rx_block_buffer: table-driven block streams checked through an output scoreboard,
// plus back-pressure and mid-traffic reset sequences.
module tb_streamer_rx_block_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] rx_data = 64'd0;
    logic        rx_valid = 1'b0, rx_first = 1'b0, rx_last = 1'b0, rx_lost = 1'b0;
    logic        rx_dreq;
    logic [63:0] blk_data;
    logic        blk_valid, blk_first, blk_last;
    logic        blk_ready = 1'b1;
    logic [15:0] stat_dropped, stat_committed;

    streamer_rx_block_buffer dut (
        .clk_sys_i        (clk),
        .rst_n_i          (rst_n),
        .rx_data_i        (rx_data),
        .rx_valid_i       (rx_valid),
        .rx_first_p1_i    (rx_first),
        .rx_last_p1_i     (rx_last),
        .rx_lost_p1_i     (rx_lost),
        .rx_dreq_o        (rx_dreq),
        .blk_data_o       (blk_data),
        .blk_valid_o      (blk_valid),
        .blk_first_o      (blk_first),
        .blk_last_o       (blk_last),
        .blk_ready_i      (blk_ready),
        .stat_dropped_o   (stat_dropped),
        .stat_committed_o (stat_committed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          scen;
        logic [63:0] data;
        logic        valid, first, last, lost, keep;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        first, last;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   fails = 0;

    logic        hold_pend = 1'b0;
    logic [63:0] hold_d;
    logic        hold_f, hold_l;

    function automatic vec_t mk(int s, logic [63:0] d, logic v, logic f, logic l, logic ls, logic k);
        vec_t r;
        r.scen = s; r.data = d; r.valid = v; r.first = f; r.last = l; r.lost = ls; r.keep = k;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Output side, sampled on the falling edge: stability under stall and scoreboard ordering
    task automatic monitor();
        exp_t e;
        if (hold_pend && blk_valid) begin
            checks++;
            if (blk_data !== hold_d || blk_first !== hold_f || blk_last !== hold_l) begin
                fails++;
                $display("FAIL stall_hold: got %0h/%b/%b, expected %0h/%b/%b",
                         blk_data, blk_first, blk_last, hold_d, hold_f, hold_l);
            end
        end
        hold_pend = blk_valid && !blk_ready;
        hold_d = blk_data; hold_f = blk_first; hold_l = blk_last;
        if (blk_valid && blk_ready) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_word: got %0h, expected no output", blk_data);
            end else begin
                e = sb.pop_front();
                if (blk_data !== e.data || blk_first !== e.first || blk_last !== e.last) begin
                    fails++;
                    $display("FAIL out_word: got %0h f=%b l=%b, expected %0h f=%b l=%b",
                             blk_data, blk_first, blk_last, e.data, e.first, e.last);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] d, input logic v, input logic f, input logic l, input logic ls);
        rx_data = d; rx_valid = v; rx_first = f; rx_last = l; rx_lost = ls;
        step();
        rx_valid = 1'b0; rx_first = 1'b0; rx_last = 1'b0; rx_lost = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        hold_pend = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: got %0d words left, expected 0", name, sb.size());
        end
        step();
        step();
    endtask

    int exp_drop[5] = '{0, 1, 1, 1, 1};
    int exp_comm[5] = '{3, 1, 1, 1, 1};

    initial begin
        exp_t e;
        int   sent_at_stall, waited;
        logic stalled;

        // block streams: sizes 1/2/3, lost mid-block, truncated block, oversize block, stray words
        vecs.push_back(mk(0, 64'd0, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 64'd1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 64'd2, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 64'd3, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 64'd4, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 64'd5, 1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 64'd10, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 64'd11, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 64'd12, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 64'd9, 1, 1, 1, 0, 1));
        vecs.push_back(mk(2, 64'd20, 1, 1, 0, 0, 0));
        vecs.push_back(mk(2, 64'd21, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2, 64'd22, 1, 1, 0, 0, 1));
        vecs.push_back(mk(2, 64'd23, 1, 0, 1, 0, 1));
        for (int i = 0; i < 9; i++) begin
            vecs.push_back(mk(3, 64'(30 + i), 1, (i == 0), (i == 8), 0, 0));
        end
        vecs.push_back(mk(3, 64'd40, 1, 1, 0, 0, 1));
        vecs.push_back(mk(3, 64'd41, 1, 0, 1, 0, 1));
        vecs.push_back(mk(4, 64'd50, 1, 0, 1, 0, 0));
        vecs.push_back(mk(4, 64'd0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4, 64'd51, 1, 1, 1, 0, 1));

        // reset state
        step();
        check("rst_valid", {63'd0, blk_valid}, 64'd0);
        check("rst_first", {63'd0, blk_first}, 64'd0);
        check("rst_last", {63'd0, blk_last}, 64'd0);
        check("rst_dreq", {63'd0, rx_dreq}, 64'd0);
        check("rst_dropped", {48'd0, stat_dropped}, 64'd0);
        check("rst_committed", {48'd0, stat_committed}, 64'd0);
        rst_n = 1'b1;
        step();
        check("dreq_after_release", {63'd0, rx_dreq}, 64'd1);

        for (int s = 0; s < 5; s++) begin
            do_reset();
            blk_ready = 1'b1;
            foreach (vecs[k]) begin
                if (vecs[k].scen == s) begin
                    if (vecs[k].keep) begin
                        e.data = vecs[k].data; e.first = vecs[k].first; e.last = vecs[k].last;
                        sb.push_back(e);
                    end
                    drive(vecs[k].data, vecs[k].valid, vecs[k].first, vecs[k].last, vecs[k].lost);
                end
            end
            drain($sformatf("scen%0d", s));
            check($sformatf("scen%0d_dropped", s), {48'd0, stat_dropped}, 64'(exp_drop[s]));
            check($sformatf("scen%0d_committed", s), {48'd0, stat_committed}, 64'(exp_comm[s]));
        end

        // back-pressure: 5 blocks of 4 words with the consumer stalled
        do_reset();
        blk_ready = 1'b0;
        stalled = 1'b0;
        sent_at_stall = -1;
        for (int i = 0; i < 20; i++) begin
            waited = 0;
            while (!rx_dreq && waited < 300) begin
                if (!stalled) begin
                    stalled = 1'b1;
                    sent_at_stall = i;
                end
                step();
                waited++;
                if (waited == 8) blk_ready = 1'b1;
            end
            if (waited >= 300) begin
                checks++;
                fails++;
                $display("FAIL dreq_timeout: got dreq=0 for %0d cycles, expected dreq=1", waited);
            end
            e.data = 64'(100 + i); e.first = ((i % 4) == 0); e.last = ((i % 4) == 3);
            sb.push_back(e);
            drive(64'(100 + i), 1'b1, ((i % 4) == 0), ((i % 4) == 3), 1'b0);
        end
        blk_ready = 1'b1;
        drain("backpressure");
        checks++;
        if (!stalled || sent_at_stall < 14 || sent_at_stall > 15) begin
            fails++;
            $display("FAIL dreq_fall: got stall after %0d words, expected 14..15", sent_at_stall);
        end
        check("bp_dropped", {48'd0, stat_dropped}, 64'd0);
        check("bp_committed", {48'd0, stat_committed}, 64'd5);

        // reset with two committed blocks pending
        do_reset();
        blk_ready = 1'b0;
        drive(64'd60, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(64'd61, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(64'd62, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check("pending_valid", {63'd0, blk_valid}, 64'd1);
        check("pending_committed", {48'd0, stat_committed}, 64'd2);
        rst_n = 1'b0;
        hold_pend = 1'b0;
        blk_ready = 1'b1;
        step();
        check("mid_rst_valid", {63'd0, blk_valid}, 64'd0);
        check("mid_rst_first", {63'd0, blk_first}, 64'd0);
        check("mid_rst_dreq", {63'd0, rx_dreq}, 64'd0);
        check("mid_rst_committed", {48'd0, stat_committed}, 64'd0);
        check("mid_rst_dropped", {48'd0, stat_dropped}, 64'd0);
        rst_n = 1'b1;
        step();
        check("mid_rst_dreq_release", {63'd0, rx_dreq}, 64'd1);
        check("mid_rst_empty", {63'd0, blk_valid}, 64'd0);
        e.data = 64'd77; e.first = 1'b1; e.last = 1'b1;
        sb.push_back(e);
        drive(64'd77, 1'b1, 1'b1, 1'b1, 1'b0);
        drain("post_reset");
        check("post_rst_committed", {48'd0, stat_committed}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
